// File: rtl/cpu_bus_responder_pkg.sv
// Shared CPU memory-map constants, region/DMA enums and the address decoder.
// Used for both CPU-issued and DMA-issued addresses.
package bus_defs;

  localparam logic [15:0] RAM_END      = 16'h1FFF;
  localparam logic [15:0] PPU_BASE     = 16'h2000;
  localparam logic [15:0] PPU_END      = 16'h3FFF;
  localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
  localparam logic [15:0] ROM_BASE     = 16'h8000;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_PPU,
    REG_DMA,
    REG_ROM,
    REG_NONE
  } region_e;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_e;

  function automatic region_e decode(input logic [15:0] a);
    region_e r;
    unique case (1'b1)
      (a <= RAM_END):                   r = REG_RAM;
      (a >= PPU_BASE && a <= PPU_END):  r = REG_PPU;
      (a == OAM_DMA_ADDR):              r = REG_DMA;
      (a >= ROM_BASE):                  r = REG_ROM;
      default:                          r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_bus_responder_ram.sv
// Internal work RAM: single port, synchronous write, read-first read.
// No reset on the array or the read register.
module cpu_ram #(
  parameter int AW = 11
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge i_clk) begin
    o_rdata <= r_mem[i_addr];
    if (i_we)
      r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU bus responder: address decode, registered read mux,
// PPU strobe generation and the OAM DMA engine.
module cpu_bus_responder
  import bus_defs::*;
#(
  parameter int RAM_AW  = 11,
  parameter bit PRG_16K = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_write_en,
  input  logic        cpu_read_en,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_halt,
  output logic [2:0]  ppu_reg_sel,
  output logic [7:0]  ppu_wdata,
  output logic        ppu_we,
  output logic        ppu_re,
  input  logic [7:0]  ppu_rdata,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        oam_dma_we,
  output logic [7:0]  oam_dma_data
);

  dma_state_e  r_state;
  logic [7:0]  r_page;
  logic [7:0]  r_n;
  logic        r_oam_we;
  logic [7:0]  r_oam_data;
  logic        r_we_d;
  logic        r_re_d;
  logic [7:0]  r_hold;
  logic        r_sel_ram;

  logic              w_halt;
  logic              w_wr_edge;
  logic              w_rd_edge;
  region_e           w_cpu_reg;
  region_e           w_dma_reg;
  logic [15:0]       w_dma_addr;
  logic [7:0]        w_n_ram;
  logic [15:0]       w_ram_addr;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_ram_we;
  logic [7:0]        w_ram_q;
  logic [15:0]       w_bus_addr;
  logic [14:0]       w_rom15;
  logic [7:0]        w_dma_byte;

  assign w_halt     = (r_state != DMA_IDLE);
  assign w_wr_edge  = cpu_write_en & ~r_we_d & ~w_halt;
  assign w_rd_edge  = cpu_read_en & ~r_re_d & ~w_halt;
  assign w_cpu_reg  = decode(cpu_addr);
  assign w_dma_addr = {r_page, r_n};
  assign w_dma_reg  = decode(w_dma_addr);

  // RAM reads one byte ahead so the DMA byte is ready in DMA_READ
  assign w_n_ram    = (r_state == DMA_WRITE) ? r_n + 8'd1 : r_n;
  assign w_ram_addr = w_halt ? {r_page, w_n_ram} : cpu_addr;
  assign w_ram_idx  = RAM_AW'(w_ram_addr);
  assign w_ram_we   = ~w_halt & cpu_write_en
                    & (w_cpu_reg == REG_RAM);

  cpu_ram #(.AW(RAM_AW)) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_idx),
    .i_wdata (cpu_wdata),
    .o_rdata (w_ram_q)
  );

  assign w_bus_addr = w_halt ? w_dma_addr : cpu_addr;
  assign w_rom15    = 15'(w_bus_addr);
  assign rom_addr   = PRG_16K ? {1'b0, w_rom15[13:0]}
                              : w_rom15;

  always_comb begin
    w_dma_byte = 8'h00;
    unique case (w_dma_reg)
      REG_RAM: w_dma_byte = w_ram_q;
      REG_ROM: w_dma_byte = rom_data;
      default: w_dma_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= DMA_IDLE;
      r_page     <= 8'h00;
      r_n        <= 8'h00;
      r_oam_we   <= 1'b0;
      r_oam_data <= 8'h00;
    end else begin
      unique case (r_state)
        DMA_IDLE: begin
          if (w_wr_edge && w_cpu_reg == REG_DMA) begin
            r_page  <= cpu_wdata;
            r_n     <= 8'h00;
            r_state <= DMA_ALIGN;
          end
        end
        DMA_ALIGN: r_state <= DMA_READ;
        DMA_READ: begin
          r_oam_we   <= 1'b1;
          r_oam_data <= w_dma_byte;
          r_state    <= DMA_WRITE;
        end
        DMA_WRITE: begin
          r_oam_we <= 1'b0;
          if (r_n == 8'hFF) begin
            r_state <= DMA_IDLE;
          end else begin
            r_n     <= r_n + 8'd1;
            r_state <= DMA_READ;
          end
        end
        default: r_state <= DMA_IDLE;
      endcase
    end
  end

  // RAM bytes come straight from the RAM read register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we_d    <= 1'b0;
      r_re_d    <= 1'b0;
      r_hold    <= 8'h00;
      r_sel_ram <= 1'b0;
    end else begin
      r_we_d    <= cpu_write_en;
      r_re_d    <= cpu_read_en;
      r_hold    <= cpu_rdata;
      r_sel_ram <= 1'b0;
      if (!w_halt) begin
        unique case (w_cpu_reg)
          REG_RAM: r_sel_ram <= 1'b1;
          REG_PPU: r_hold    <= ppu_rdata;
          REG_ROM: r_hold    <= rom_data;
          default: r_sel_ram <= 1'b0;
        endcase
      end
    end
  end

  assign cpu_rdata    = r_sel_ram ? w_ram_q : r_hold;
  assign cpu_halt     = w_halt;
  assign ppu_reg_sel  = w_halt ? 3'd0 : cpu_addr[2:0];
  assign ppu_wdata    = cpu_wdata;
  assign ppu_we       = w_wr_edge & (w_cpu_reg == REG_PPU);
  assign ppu_re       = w_rd_edge & (w_cpu_reg == REG_PPU);
  assign oam_dma_we   = r_oam_we;
  assign oam_dma_data = r_oam_data;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Randomised scoreboard bench for cpu_bus_responder.
// Reference model works from the memory map, not the RTL.
module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_write_en = 1'b0;
  logic        cpu_read_en = 1'b0;
  logic [7:0]  ppu_base = 8'h82;

  logic [7:0]  cpu_rdata, cpu_rdata16;
  logic        cpu_halt, cpu_halt16;
  logic [2:0]  ppu_reg_sel, ppu_reg_sel16;
  logic [7:0]  ppu_wdata, ppu_wdata16;
  logic        ppu_we, ppu_we16, ppu_re, ppu_re16;
  logic [7:0]  ppu_rdata;
  logic [14:0] rom_addr, rom_addr16;
  logic [7:0]  rom_data, rom_data16;
  logic        oam_dma_we, oam_dma_we16;
  logic [7:0]  oam_dma_data, oam_dma_data16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
  endfunction

  assign ppu_rdata  = ppu_base ^ {5'd0, ppu_reg_sel};
  assign rom_data   = rom_fn(rom_addr);
  assign rom_data16 = rom_fn(rom_addr16);

  cpu_bus_responder #(.RAM_AW(11), .PRG_16K(1'b0)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en),
    .cpu_rdata(cpu_rdata), .cpu_halt(cpu_halt),
    .ppu_reg_sel(ppu_reg_sel), .ppu_wdata(ppu_wdata),
    .ppu_we(ppu_we), .ppu_re(ppu_re), .ppu_rdata(ppu_rdata),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .oam_dma_we(oam_dma_we), .oam_dma_data(oam_dma_data)
  );

  cpu_bus_responder #(.RAM_AW(11), .PRG_16K(1'b1)) dut16 (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en),
    .cpu_rdata(cpu_rdata16), .cpu_halt(cpu_halt16),
    .ppu_reg_sel(ppu_reg_sel16), .ppu_wdata(ppu_wdata16),
    .ppu_we(ppu_we16), .ppu_re(ppu_re16), .ppu_rdata(ppu_rdata),
    .rom_addr(rom_addr16), .rom_data(rom_data16),
    .oam_dma_we(oam_dma_we16), .oam_dma_data(oam_dma_data16)
  );

  typedef struct { logic [7:0] rd; bit v; bit halt; } reg_e;
  typedef struct {
    bit we; bit re; bit live;
    logic [2:0] sel; logic [14:0] ra; logic [14:0] ra16;
    logic [7:0] wd;
  } comb_e;
  typedef struct { logic [7:0] d; bit v; } oam_e;

  reg_e  reg_q[$];
  comb_e comb_q[$];
  oam_e  oam_q[$];

  logic [7:0] ram_m [2048];
  bit         ram_v [2048];
  logic [7:0] hold = 8'h00;
  bit         hold_v = 1'b1;
  int         halt_left = 0;
  bit         prev_we = 1'b0;
  bit         prev_re = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void src_read(input logic [15:0] a, input bit dma,
                                   output logic [7:0] d, output bit v);
    int idx;
    idx = int'(a) % 2048;
    if (a < 16'h2000) begin
      d = ram_m[idx];
      v = ram_v[idx];
    end else if (a < 16'h4000) begin
      d = dma ? 8'h00 : (ppu_base ^ 8'(a % 8));
      v = 1'b1;
    end else if (a >= 16'h8000) begin
      d = rom_fn(15'(a - 16'h8000));
      v = 1'b1;
    end else begin
      d = dma ? 8'h00 : hold;
      v = dma ? 1'b1 : hold_v;
    end
  endfunction

  task automatic cyc(input logic [15:0] a, input logic [7:0] wd,
                     input bit we, input bit re);
    comb_e c;
    reg_e r;
    oam_e o;
    logic [7:0] d;
    bit v, halted, ppu;
    cpu_addr = a;
    cpu_wdata = wd;
    cpu_write_en = we;
    cpu_read_en = re;
    halted = halt_left > 0;
    ppu = (a >= 16'h2000) && (a < 16'h4000);
    c.we = !halted && we && !prev_we && ppu;
    c.re = !halted && re && !prev_re && ppu;
    c.live = !halted;
    c.sel = 3'(a % 8);
    c.ra = 15'(a % 16'h8000);
    c.ra16 = 15'(a % 16'h4000);
    c.wd = wd;
    comb_q.push_back(c);
    if (halted) begin
      halt_left--;
    end else begin
      src_read(a, 1'b0, d, v);
      hold = d;
      hold_v = v;
      if (we && a < 16'h2000) begin
        ram_m[int'(a) % 2048] = wd;
        ram_v[int'(a) % 2048] = 1'b1;
      end
      if (we && !prev_we && a == 16'h4014) begin
        halt_left = 513;
        for (int i = 0; i < 256; i++) begin
          src_read(16'(int'(wd) * 256 + i), 1'b1, d, v);
          o.d = d;
          o.v = v;
          oam_q.push_back(o);
        end
      end
    end
    prev_we = we;
    prev_re = re;
    @(posedge clk);
    r.rd = hold;
    r.v = hold_v;
    r.halt = halt_left > 0;
    reg_q.push_back(r);
    #1;
  endtask

  task automatic rnd_cyc();
    logic [15:0] a;
    logic [7:0] wd;
    logic [7:0] pages [4];
    int r;
    pages[0] = 8'h02; pages[1] = 8'h81;
    pages[2] = 8'h21; pages[3] = 8'h50;
    r = $urandom_range(0, 39);
    if (r < 12)
      a = 16'(($urandom_range(0, 3) << 11) + 'h200 + $urandom_range(0, 15));
    else if (r < 22)
      a = 16'h2000 + 16'($urandom_range(0, 'h1FFF));
    else if (r < 30)
      a = 16'h8000 + 16'($urandom_range(0, 'h7FFF));
    else if (r < 39)
      a = 16'h4000 + 16'($urandom_range(0, 'h3FFF));
    else
      a = 16'h4014;
    wd = 8'($urandom);
    if (a == 16'h4014)
      wd = pages[$urandom_range(0, 3)];
    cyc(a, wd, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    cpu_write_en = 1'b0;
    cpu_read_en = 1'b0;
    reg_q.delete();
    comb_q.delete();
    oam_q.delete();
    halt_left = 0;
    prev_we = 1'b0;
    prev_re = 1'b0;
    hold = 8'h00;
    hold_v = 1'b1;
    #1;
    chk("rst_halt", 16'(cpu_halt), 16'd0);
    chk("rst_oam_we", 16'(oam_dma_we), 16'd0);
    chk("rst_rdata", 16'(cpu_rdata), 16'h00);
    chk("rst_oam_data", 16'(oam_dma_data), 16'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    reg_e r;
    comb_e c;
    oam_e o;
    if (rst) begin
      if (reg_q.size() > 0) begin
        r = reg_q.pop_front();
        if (r.v) chk("cpu_rdata", 16'(cpu_rdata), 16'(r.rd));
        chk("cpu_halt", 16'(cpu_halt), 16'(r.halt));
      end
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        chk("ppu_we", 16'(ppu_we), 16'(c.we));
        chk("ppu_re", 16'(ppu_re), 16'(c.re));
        if (c.live) begin
          chk("ppu_reg_sel", 16'(ppu_reg_sel), 16'(c.sel));
          chk("ppu_wdata", 16'(ppu_wdata), 16'(c.wd));
          chk("rom_addr", 16'(rom_addr), 16'(c.ra));
          chk("rom_addr_16k", 16'(rom_addr16), 16'(c.ra16));
        end
      end
      if (oam_dma_we === 1'b1) begin
        if (oam_q.size() == 0) begin
          chk("oam_extra", 16'(oam_dma_we), 16'd0);
        end else begin
          o = oam_q.pop_front();
          if (o.v) chk("oam_dma_data", 16'(oam_dma_data), 16'(o.d));
        end
      end
    end
  end

  initial begin
    int cnt;
    #3;
    do_reset();
    cyc(16'h0005, 8'h77, 1'b1, 1'b0);
    cyc(16'h0005, 8'h3C, 1'b1, 1'b0);
    cyc(16'h0805, 8'h00, 1'b0, 1'b0);
    cyc(16'h1805, 8'h00, 1'b0, 1'b0);
    repeat (2) cyc(16'h2006, 8'h21, 1'b1, 1'b0);
    cyc(16'h2006, 8'h00, 1'b0, 1'b0);
    repeat (2) cyc(16'h3FFE, 8'h21, 1'b1, 1'b0);
    cyc(16'h0000, 8'h00, 1'b0, 1'b0);
    repeat (2) cyc(16'h2002, 8'h00, 1'b0, 1'b1);
    cyc(16'h2002, 8'h00, 1'b0, 1'b0);
    cyc(16'h8123, 8'h00, 1'b0, 1'b0);
    cyc(16'h5000, 8'h00, 1'b0, 1'b0);
    cyc(16'hC123, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++)
      cyc(16'h0200 + 16'(i), 8'(i), 1'b1, 1'b0);
    cyc(16'h0000, 8'h00, 1'b0, 1'b0);
    cyc(16'h4014, 8'h02, 1'b1, 1'b0);
    repeat (513)
      cyc(16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    cyc(16'h0000, 8'h00, 1'b0, 1'b0);
    cyc(16'h0205, 8'h00, 1'b0, 1'b0);
    cyc(16'h1AFF, 8'h00, 1'b0, 1'b0);
    repeat (300) rnd_cyc();
    while (halt_left > 0) rnd_cyc();
    cyc(16'h0000, 8'h00, 1'b0, 1'b0);
    cyc(16'h4014, 8'h02, 1'b1, 1'b0);
    cnt = 0;
    for (int k = 0; k < 600 && cnt < 100; k++) begin
      cyc(16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if (oam_dma_we === 1'b1) cnt++;
    end
    chk("mid_dma_reached", 16'(cnt), 16'd100);
    do_reset();
    cyc(16'h0000, 8'h00, 1'b0, 1'b0);
    cyc(16'h4014, 8'h02, 1'b1, 1'b0);
    repeat (513)
      cyc(16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    repeat (3) cyc(16'h0000, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("oam_left", 16'(oam_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
